// File: rtl/sreg_siso_ctrl.sv
// Word-level command sequencer for a serial-in/serial-out shift register.
// Turns WRITE/READ/EXCHANGE/CLEAR requests into MSB-first bit streams and gathers sout into a word.
module sreg_siso_ctrl #(
    parameter int unsigned NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [1:0]       req_type,
    input  logic [NBITS-1:0] req_msg,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_msg,
    output logic             sreg_en,
    output logic             sreg_sin,
    output logic             sreg_clr,
    input  logic             sreg_sout
);

    localparam int unsigned CntW = $clog2(NBITS);
    localparam logic [CntW-1:0] LastCnt = CntW'(NBITS - 1);

    localparam logic [1:0] TypeWrite = 2'd0;
    localparam logic [1:0] TypeRead  = 2'd1;
    localparam logic [1:0] TypeClear = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StClr,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       type_q, type_d;
    logic [NBITS-1:0] data_q, data_d;
    logic [NBITS-1:0] capt_q, capt_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             req_rdy_q, req_rdy_d;
    logic             resp_val_q, resp_val_d;
    logic [NBITS-1:0] resp_msg_q, resp_msg_d;
    logic             sreg_en_q, sreg_en_d;
    logic             sreg_sin_q, sreg_sin_d;
    logic             sreg_clr_q, sreg_clr_d;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        data_d  = data_q;
        capt_d  = capt_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_val) begin
                    type_d  = req_type;
                    data_d  = req_msg;
                    cnt_d   = '0;
                    capt_d  = '0;
                    state_d = (req_type == TypeClear) ? StClr : StShift;
                end
            end
            StShift: begin
                // sout is the pre-shift MSB, so bit cnt of the old word lands MSB-first
                if (type_q != TypeWrite) begin
                    capt_d[LastCnt - cnt_q] = sreg_sout;
                end
                if (cnt_q == LastCnt) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StClr: begin
                capt_d  = '0;
                state_d = StResp;
            end
            StResp: begin
                if (resp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe
        req_rdy_d  = (state_d == StIdle);
        resp_val_d = (state_d == StResp);
        resp_msg_d = (state_d == StResp) ? capt_d : '0;
        sreg_en_d  = (state_d == StShift);
        sreg_sin_d = sreg_en_d && (type_d != TypeRead) && data_d[LastCnt - cnt_d];
        sreg_clr_d = (state_d == StClr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            type_q     <= TypeWrite;
            data_q     <= '0;
            capt_q     <= '0;
            cnt_q      <= '0;
            req_rdy_q  <= 1'b1;
            resp_val_q <= 1'b0;
            resp_msg_q <= '0;
            sreg_en_q  <= 1'b0;
            sreg_sin_q <= 1'b0;
            sreg_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            data_q     <= data_d;
            capt_q     <= capt_d;
            cnt_q      <= cnt_d;
            req_rdy_q  <= req_rdy_d;
            resp_val_q <= resp_val_d;
            resp_msg_q <= resp_msg_d;
            sreg_en_q  <= sreg_en_d;
            sreg_sin_q <= sreg_sin_d;
            sreg_clr_q <= sreg_clr_d;
        end
    end

    assign req_rdy  = req_rdy_q;
    assign resp_val = resp_val_q;
    assign resp_msg = resp_msg_q;
    assign sreg_en  = sreg_en_q;
    assign sreg_sin = sreg_sin_q;
    assign sreg_clr = sreg_clr_q;

endmodule
